// File: rtl/ecg_pkg.sv
// Shared ECG sample definitions: conversion modes, default widths and the
// raw-ADC-to-signed-sample conversion used on the FIFO write side.
package ecg_pkg;

  localparam int ECG_DATA_WIDTH  = 11;
  localparam int ECG_CTR_WIDTH   = 22;
  localparam int ECG_DATA_OFFSET = 1024;

  typedef enum logic [1:0] {
    CONV_PASS    = 2'd0,
    CONV_OFFSET  = 2'd1,
    CONV_MSB_TAG = 2'd2
  } conv_mode_e;

  // Converts a raw code of 'width' bits (width <= 32) into a sample.
  // The result occupies the low 'width' bits; callers truncate to their
  // sample width and reinterpret it as signed.
  function automatic logic [31:0] ecg_conv(input logic [31:0] raw,
                                           input conv_mode_e  mode,
                                           input int          offset,
                                           input int          width);
    logic [31:0] mask;
    logic [31:0] diff;
    logic [31:0] low;
    logic        tag;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    diff = (raw - 32'(offset)) & mask;
    low  = raw & (mask >> 1);
    tag  = ((raw >> (width - 1)) & 32'd1) != 32'd0;
    case (mode)
      CONV_PASS:    ecg_conv = raw & mask;
      CONV_MSB_TAG: ecg_conv = tag ? low : diff;
      default:      ecg_conv = diff;
    endcase
  endfunction

endpackage

// File: rtl/ecg_sample_fifo_sdp_ram.sv
// Simple dual-port memory: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module sdp_ram #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array write; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its word while no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ecg_sample_fifo.sv
// Sample FIFO between the ECG sample source and alg_core. Converts raw ADC
// codes on write, tags each push with an acquisition index, and reports
// occupancy, thresholds, dropped pushes and empty pops.
//
// Handshake: push is a write request taken when the FIFO is not full or a
// pop is taken in the same cycle; pop is a read request taken when the FIFO
// is not empty. One cycle after a taken pop, rdata_valid pulses high for one
// cycle with rdata/rdata_idx; otherwise rdata/rdata_idx hold their values.
module ecg_sample_fifo
  import ecg_pkg::*;
#(
  parameter int DATA_WIDTH  = ECG_DATA_WIDTH,
  parameter int CTR_WIDTH   = ECG_CTR_WIDTH,
  parameter int DEPTH       = 1024,
  parameter int DATA_OFFSET = ECG_DATA_OFFSET,
  parameter int CONV_MODE   = 2,
  parameter int AF_LEVEL    = DEPTH - 4,
  parameter int AE_LEVEL    = 4,
  parameter int OVF_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         pop,
  output logic signed [DATA_WIDTH-1:0] rdata,
  output logic [CTR_WIDTH-1:0]         rdata_idx,
  output logic                         rdata_valid,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [OVF_WIDTH-1:0]         overflow_cnt,
  output logic                         underflow,
  input  logic                         clr_flags
);

  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WORD_W = DATA_WIDTH + CTR_WIDTH;

  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_L     = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0] AE_L     = LVL_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CTR_WIDTH-1:0]  idx_ctr;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  push_drop;
  logic                  pop_empty;
  logic [LVL_W-1:0]      level_nxt;
  logic [DATA_WIDTH-1:0] conv_sample;
  logic [WORD_W-1:0]     wr_word;
  logic [WORD_W-1:0]     rd_word;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  always_comb begin
    push_acc  = push && (!full || pop);
    pop_acc   = pop && !empty;
    push_drop = push && full && !pop;
    pop_empty = pop && empty;
    level_nxt = level + LVL_W'(push_acc) - LVL_W'(pop_acc);
  end

  assign conv_sample = DATA_WIDTH'(ecg_conv(32'(wdata), conv_mode_e'(CONV_MODE),
                                            DATA_OFFSET, DATA_WIDTH));
  assign wr_word     = {idx_ctr, conv_sample};

  sdp_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .re    (pop_acc),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  assign rdata     = rd_word[DATA_WIDTH-1:0];
  assign rdata_idx = rd_word[WORD_W-1:DATA_WIDTH];

  // Pointers, occupancy and its registered flags, advanced together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rdata_valid  <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      level        <= level_nxt;
      full         <= (level_nxt == DEPTH_L);
      almost_full  <= (level_nxt >= AF_L);
      empty        <= (level_nxt == '0);
      almost_empty <= (level_nxt <= AE_L);
      rdata_valid  <= pop_acc;
    end
  end

  // Acquisition index counts every push request, dropped ones included.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_ctr <= '0;
    end else if (push) begin
      idx_ctr <= idx_ctr + 1'b1;
    end
  end

  // Error flags; an event in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_cnt <= '0;
      underflow    <= 1'b0;
    end else begin
      if (push_drop) begin
        if (clr_flags) begin
          overflow_cnt <= OVF_WIDTH'(1);
        end else if (overflow_cnt != '1) begin
          overflow_cnt <= overflow_cnt + 1'b1;
        end
      end else if (clr_flags) begin
        overflow_cnt <= '0;
      end
      if (pop_empty) begin
        underflow <= 1'b1;
      end else if (clr_flags) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ecg_sample_fifo.sv
// Bench for ecg_sample_fifo: directed scenarios with literal expectations
// plus randomized traffic, all checked against a queue-based model.
module tb_ecg_sample_fifo;

  localparam int DW     = 11;
  localparam int CW     = 22;
  localparam int DEPTH  = 5;
  localparam int OFFSET = 1024;
  localparam int MODE   = 2;
  localparam int AF     = 3;
  localparam int AE     = 1;
  localparam int OW     = 2;
  localparam int LW     = $clog2(DEPTH + 1);

  // clock / reset / stimulus signals
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          pop = 1'b0;
  logic          clr_flags = 1'b0;
  logic          full, almost_full, rdata_valid, empty, almost_empty, underflow;
  logic [DW-1:0] rdata;
  logic [CW-1:0] rdata_idx;
  logic [LW-1:0] level;
  logic [OW-1:0] overflow_cnt;

  always #5 clk = ~clk;

  ecg_sample_fifo #(
    .DATA_WIDTH (DW), .CTR_WIDTH (CW), .DEPTH (DEPTH), .DATA_OFFSET (OFFSET),
    .CONV_MODE (MODE), .AF_LEVEL (AF), .AE_LEVEL (AE), .OVF_WIDTH (OW)
  ) dut (
    .clk (clk), .rst (rst), .push (push), .wdata (wdata), .full (full),
    .almost_full (almost_full), .pop (pop), .rdata (rdata),
    .rdata_idx (rdata_idx), .rdata_valid (rdata_valid), .empty (empty),
    .almost_empty (almost_empty), .level (level),
    .overflow_cnt (overflow_cnt), .underflow (underflow),
    .clr_flags (clr_flags)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each entry is {index, converted sample}.
  logic [CW+DW-1:0] exp_q[$];
  logic [CW-1:0]    m_idx = '0;
  int               m_ovf = 0;
  bit               m_uf = 1'b0;
  logic [DW-1:0]    m_rdata = '0;
  logic [CW-1:0]    m_ridx = '0;
  bit               m_valid = 1'b0;

  function automatic logic [DW-1:0] model_conv(input logic [DW-1:0] raw);
    int v;
    if (MODE == 0) return raw;
    if (MODE == 2 && raw[DW-1]) return {1'b0, raw[DW-2:0]};
    v = int'(raw) - OFFSET;
    return v[DW-1:0];
  endfunction

  always @(posedge clk) begin
    bit is_full, is_empty, pop_ok, push_ok, dropped, uf_evt;
    logic [CW+DW-1:0] e;
    if (rst) begin
      exp_q.delete();
      m_idx = '0; m_ovf = 0; m_uf = 1'b0;
      m_rdata = '0; m_ridx = '0; m_valid = 1'b0;
    end else begin
      is_full  = (exp_q.size() == DEPTH);
      is_empty = (exp_q.size() == 0);
      pop_ok   = pop && !is_empty;
      push_ok  = push && (!is_full || pop);
      dropped  = push && !push_ok;
      uf_evt   = pop && is_empty;
      m_valid  = pop_ok;
      if (pop_ok) begin
        e = exp_q.pop_front();
        m_rdata = e[DW-1:0];
        m_ridx  = e[CW+DW-1:DW];
      end
      if (push_ok) exp_q.push_back({m_idx, model_conv(wdata)});
      if (push) m_idx = m_idx + 1'b1;
      if (dropped) m_ovf = clr_flags ? 1 : ((m_ovf == (1 << OW) - 1) ? m_ovf : m_ovf + 1);
      else if (clr_flags) m_ovf = 0;
      if (uf_evt) m_uf = 1'b1;
      else if (clr_flags) m_uf = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (checking) begin
      check("level",        32'(level),        32'(exp_q.size()));
      check("full",         32'(full),         32'(exp_q.size() == DEPTH));
      check("empty",        32'(empty),        32'(exp_q.size() == 0));
      check("almost_full",  32'(almost_full),  32'(exp_q.size() >= AF));
      check("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= AE));
      check("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_uf));
      check("rdata_valid",  32'(rdata_valid),  32'(m_valid));
      check("rdata",        32'(rdata),        32'(m_rdata));
      check("rdata_idx",    32'(rdata_idx),    32'(m_ridx));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input bit r, input bit p, input logic [DW-1:0] d, input bit o, input bit c);
    rst = r; push = p; wdata = d; pop = o; clr_flags = c;
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic do_push(input logic [DW-1:0] d); tick(0, 1, d, 0, 0); endtask
  task automatic do_pop();                        tick(0, 0, '0, 1, 0); endtask
  task automatic do_reset();                      tick(1, 0, '0, 0, 0); endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    #2;
    do_reset();
    do_reset();
    checking = 1'b1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ae",    32'(almost_empty), 32'd1);
    check("rst_full",  32'(full), 32'd0);
    check("rst_valid", 32'(rdata_valid), 32'd0);

    // Offset conversion: 0x400 -> 0, 0x7FF -> 1023, 0x000 -> -1024
    do_push(11'h400); do_push(11'h7FF); do_push(11'h000);
    do_pop();
    check("p1_valid", 32'(rdata_valid), 32'd1);
    check("p1_data",  32'(rdata), 32'd0);
    check("p1_idx",   32'(rdata_idx), 32'd0);
    do_pop();
    check("p2_data",  32'(rdata), 32'd1023);
    check("p2_idx",   32'(rdata_idx), 32'd1);
    do_pop();
    check("p3_data",  32'(rdata), 32'h400);
    check("p3_idx",   32'(rdata_idx), 32'd2);
    tick(0, 0, '0, 0, 0);
    check("hold_valid", 32'(rdata_valid), 32'd0);
    check("hold_data",  32'(rdata), 32'h400);

    // MSB-tagged: 0x405 -> 5, 0x3FF -> -1
    do_push(11'h405); do_push(11'h3FF);
    do_pop();
    check("tag_data", 32'(rdata), 32'd5);
    do_pop();
    check("neg1_data", 32'(rdata), 32'h7FF);

    // Overflow with index gaps
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_push(11'(i));
      if (i == 4) check("full_after5", 32'(full), 32'd1);
    end
    check("ovf_two",  32'(overflow_cnt), 32'd2);
    check("lvl_five", 32'(level), 32'd5);
    for (int i = 0; i < 5; i++) begin
      do_pop();
      check("drain_idx", 32'(rdata_idx), 32'(i));
    end
    do_push(11'h123);
    do_pop();
    check("gap_idx", 32'(rdata_idx), 32'd7);

    // Full FIFO streaming across pointer wrap
    tick(0, 0, '0, 0, 1);
    for (int i = 0; i < 5; i++) do_push(11'(i));
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 11'($urandom_range(0, 2047)), 1, 0);
      check("stream_lvl", 32'(level), 32'd5);
      check("stream_idx", 32'(rdata_idx), 32'(8 + i));
    end
    check("stream_ovf", 32'(overflow_cnt), 32'd0);
    for (int i = 0; i < 5; i++) do_pop();
    check("stream_last_idx", 32'(rdata_idx), 32'd22);

    // Empty pop with simultaneous push
    tick(0, 1, 11'h500, 1, 0);
    check("uf_set",   32'(underflow), 32'd1);
    check("uf_valid", 32'(rdata_valid), 32'd0);
    check("uf_level", 32'(level), 32'd1);
    tick(0, 0, '0, 0, 1);
    check("uf_clr", 32'(underflow), 32'd0);
    do_pop();

    // Thresholds and mid-stream reset
    do_reset();
    do_push(11'h001);
    check("ae_lvl1", 32'(almost_empty), 32'd1);
    do_push(11'h002);
    check("ae_lvl2", 32'(almost_empty), 32'd0);
    check("af_lvl2", 32'(almost_full), 32'd0);
    do_push(11'h003);
    check("af_lvl3", 32'(almost_full), 32'd1);
    do_push(11'h004);
    check("lvl4", 32'(level), 32'd4);
    do_reset();
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_level", 32'(level), 32'd0);
    do_push(11'h055);
    do_pop();
    check("post_rst_idx", 32'(rdata_idx), 32'd0);

    // Saturating overflow counter, then clear racing a drop
    for (int i = 0; i < 10; i++) do_push(11'(i));
    check("ovf_sat", 32'(overflow_cnt), 32'd3);
    tick(0, 1, 11'h0AA, 0, 1);
    check("ovf_clr_race", 32'(overflow_cnt), 32'd1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 60,
           11'($urandom_range(0, 2047)),
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 19) == 0);
    end
    tick(0, 0, '0, 0, 0);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
